// File: rtl/sixbit_ilog_if.sv
// sixbit_ilog_if: start/done handshake bundle for the sequential integer log unit.
//   start  requester -> unit  request pulse, accepted only while the unit is idle
//   base   requester -> unit  log base b, captured with an accepted start
//   value  requester -> unit  argument v, captured with an accepted start
//   busy   unit -> requester  high while iterating
//   done   unit -> requester  one-cycle result strobe
//   exp    unit -> requester  exponent e = floor(log_b v)
//   exact  unit -> requester  b^e == v
//   err    unit -> requester  result undefined (b<2 or v==0)
interface sixbit_ilog_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] exp;
    logic             exact;
    logic             err;

    modport master (
        output start, base, value,
        input  busy, done, exp, exact, err
    );

    modport slave (
        input  start, base, value,
        output busy, done, exp, exact, err
    );
endinterface

// File: rtl/sixbit_ilog.sv
// sixbit_ilog: sequential integer logarithm, the inverse of the six-bit power unit.
//   Computes e = floor(log_b v) and exact = (b^e == v) with one WIDTH x WIDTH
//   multiply per cycle, under a start/done handshake.
// Ports:
//   clk    clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset; aborts any operation without a done pulse
//   bus    sixbit_ilog_if slave: start/base/value in, busy/done/exp/exact/err out
module sixbit_ilog #(
    parameter int WIDTH    = 6,
    parameter int MAX_ITER = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    sixbit_ilog_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   v_q, v_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic               exact_q, exact_d;
    logic               err_q, err_d;

    // Full-width product: anything above 2^WIDTH-1 already exceeds V and ends
    // the search, so acc itself never has to hold a wrapped value.
    logic [2*WIDTH-1:0] prod;
    logic               step_ok;

    assign prod    = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, b_q};
    assign step_ok = (prod <= {{WIDTH{1'b0}}, v_q}) && (cnt_q < WIDTH'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            v_q     <= '0;
            acc_q   <= WIDTH'(1);
            cnt_q   <= '0;
            exp_q   <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        v_d     = v_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        exact_d = exact_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    b_d = bus.base;
                    v_d = bus.value;
                    if ((bus.base < WIDTH'(2)) || (bus.value == '0)) begin
                        // Undefined log: report immediately, skip iteration.
                        err_d   = 1'b1;
                        exp_d   = '0;
                        exact_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        acc_d   = WIDTH'(1);
                        cnt_d   = '0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (step_ok) begin
                    acc_d = prod[WIDTH-1:0];
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    // acc holds b^cnt, the largest power not above V.
                    exp_d   = cnt_q;
                    exact_d = (acc_q == v_q);
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_q == ITER);
    assign bus.done  = (state_q == DONE);
    assign bus.exp   = exp_q;
    assign bus.exact = exact_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_sixbit_ilog.sv
module tb_sixbit_ilog;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sixbit_ilog_if #(.WIDTH(6)) bus ();

    sixbit_ilog #(.WIDTH(6), .MAX_ITER(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference: plain integer search for the largest power of b not above v.
    function automatic void ref_log(input int b, input int v,
                                    output int e, output bit x, output bit er);
        int p;
        if (b < 2 || v == 0) begin
            e = 0; x = 1'b0; er = 1'b1;
        end else begin
            p = 1; e = 0;
            while (p * b <= v && e < 10) begin
                p = p * b;
                e++;
            end
            x = (p == v); er = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model state: an accepted request is pending; rem = clock edges left until
    // the done cycle (0 means this cycle is the done cycle).
    bit pending = 1'b0;
    int rem = 0;
    int m_e = 0;
    bit m_x = 1'b0;
    bit m_er = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else if (pending) begin
            if (rem == 0) pending = 1'b0;
            else rem--;
        end else if (bus.start) begin
            ref_log(int'(bus.base), int'(bus.value), m_e, m_x, m_er);
            pending = 1'b1;
            rem = m_er ? 0 : m_e + 1;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_exp", int'(bus.exp), 0);
            chk("rst_exact", int'(bus.exact), 0);
            chk("rst_err", int'(bus.err), 0);
        end else begin
            chk("busy", int'(bus.busy), int'(pending && rem > 0));
            chk("done", int'(bus.done), int'(pending && rem == 0));
            if (pending && rem == 0) begin
                chk("exp", int'(bus.exp), m_e);
                chk("exact", int'(bus.exact), int'(m_x));
                chk("err", int'(bus.err), int'(m_er));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) chk("idle_timeout", n, 0);
    endtask

    // Directed op with literal expectations: lat = edges after the accept edge
    // until done is visible (0 for the error path).
    task automatic run_op(input string name, input int b, input int v,
                          input int e, input int x, input int er, input int lat);
        int n = 0;
        wait_idle();
        bus.start = 1'b1; bus.base = 6'(b); bus.value = 6'(v);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.base = 6'(~b); bus.value = 6'(~v);
        while (!bus.done && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_lat"}, n, lat);
        chk({name, "_exp"}, int'(bus.exp), e);
        chk({name, "_exact"}, int'(bus.exact), x);
        chk({name, "_err"}, int'(bus.err), er);
        @(posedge clk); #1;
        chk({name, "_pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        int e; bit x, er;
        bus.start = 1'b0; bus.base = '0; bus.value = '0;

        // Pin the model on hand-computed values.
        ref_log(2, 63, e, x, er); chk("model_2_63", e * 4 + x * 2 + er, 20);
        ref_log(3, 27, e, x, er); chk("model_3_27", e * 4 + x * 2 + er, 14);
        ref_log(8, 63, e, x, er); chk("model_8_63", e * 4 + x * 2 + er, 4);
        ref_log(63, 63, e, x, er); chk("model_63_63", e * 4 + x * 2 + er, 6);
        ref_log(4, 0, e, x, er); chk("model_4_0", e * 4 + x * 2 + er, 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("b2v63", 2, 63, 5, 0, 0, 6);
        run_op("b3v27", 3, 27, 3, 1, 0, 4);
        run_op("b8v63", 8, 63, 1, 0, 0, 2);
        run_op("b7v5", 7, 5, 0, 0, 0, 1);
        run_op("b5v1", 5, 1, 0, 1, 0, 1);
        run_op("b63v63", 63, 63, 1, 1, 0, 2);
        run_op("b1v9", 1, 9, 0, 0, 1, 0);
        run_op("b4v0", 4, 0, 0, 0, 1, 0);

        // Start while busy is ignored.
        wait_idle();
        bus.start = 1'b1; bus.base = 6'd2; bus.value = 6'd40;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base = 6'd3; bus.value = 6'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        begin
            int n = 0;
            while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
            chk("busy_ign_exp", int'(bus.exp), 5);
            chk("busy_ign_exact", int'(bus.exact), 0);
        end

        // Reset mid-operation.
        wait_idle();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base = 6'd2; bus.value = 6'd63;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("b2v16", 2, 16, 4, 1, 0, 5);

        // Randomized traffic: starts at any time, inputs churning, rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            bus.start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       bus.base = 6'($urandom_range(0, 1));
                1:       bus.base = 6'd2;
                default: bus.base = 6'($urandom);
            endcase
            bus.value = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
        end
        bus.start = 1'b0;
        repeat (12) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
